// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the sequential chunked ALU: operation
//               encodings and the controller state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation encodings carried on the 2-bit op field
    typedef logic [1:0] op_t;
    localparam op_t OP_AND = 2'b00;
    localparam op_t OP_OR  = 2'b01;
    localparam op_t OP_ADD = 2'b10;
    localparam op_t OP_SUB = 2'b11;

    // Controller states
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // True for the two arithmetic operations
    function automatic logic is_arith(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Request/response bundle of the sequential ALU.
//               Request : op, i0, i1, in_valid / in_ready
//               Response: o, cout, zero, ovf, out_valid / out_ready
//               master = requester/consumer, slave = the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       op;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] o;
    logic             cout;
    logic             zero;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output op, i0, i1, in_valid, out_ready,
        input  in_ready, o, cout, zero, ovf, out_valid
    );

    modport slave (
        input  op, i0, i1, in_valid, out_ready,
        output in_ready, o, cout, zero, ovf, out_valid
    );
endinterface : alu_seq_if
`default_nettype wire

// File: rtl/alu_chunk.sv
`default_nettype none
// ============================================================================
// Module      : alu_chunk
// Description : Purely combinational CHUNK-bit ALU slice.
// Ports       : op_i   - operation (alu_pkg encodings)
//               a_i    - slice of first operand
//               b_i    - slice of second operand (inverted here for SUB)
//               cin_i  - carry into bit 0 of the slice
//               s_o    - slice result
//               cout_o - carry out of the slice top bit (0 for logic ops)
//               ctop_o - carry into the slice top bit (0 for logic ops)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_chunk
    import alu_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  wire logic [1:0]       op_i,
    input  wire logic [CHUNK-1:0] a_i,
    input  wire logic [CHUNK-1:0] b_i,
    input  wire logic             cin_i,
    output logic      [CHUNK-1:0] s_o,
    output logic                  cout_o,
    output logic                  ctop_o
);

    logic [CHUNK-1:0] w_b;
    logic [CHUNK:0]   w_sum;

    always_comb begin
        w_b    = (op_i == OP_SUB) ? ~b_i : b_i;
        w_sum  = {1'b0, a_i} + {1'b0, w_b} + {{CHUNK{1'b0}}, cin_i};
        s_o    = '0;
        cout_o = 1'b0;
        ctop_o = 1'b0;
        case (op_i)
            OP_AND: s_o = a_i & b_i;
            OP_OR:  s_o = a_i | b_i;
            default: begin
                s_o    = w_sum[CHUNK-1:0];
                cout_o = w_sum[CHUNK];
                // Sum bit = a ^ b ^ carry-in, so the carry entering the top
                // bit falls out of the top sum bit without a second adder.
                ctop_o = w_sum[CHUNK-1] ^ a_i[CHUNK-1] ^ w_b[CHUNK-1];
            end
        endcase
    end

endmodule : alu_chunk
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequential ALU processing CHUNK bits per cycle through one
//               time-multiplexed alu_chunk slice. Accepts a request in IDLE,
//               spends WIDTH/CHUNK cycles in RUN, then presents the result in
//               DONE until the consumer takes it.
// Ports       : clk - clock, rising edge
//               rst - synchronous active-high reset
//               bus - alu_seq_if.slave (request and response handshakes)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input wire logic   clk,
    input wire logic   rst,
    alu_seq_if.slave   bus
);

    localparam int N     = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) ||
            (((CHUNK >= 1) ? (WIDTH % CHUNK) : 1) != 0)) begin : g_param_check
            $error("alu_seq: illegal WIDTH/CHUNK combination");
        end
    endgenerate

    state_t           state_q,  state_d;
    logic [1:0]       op_q,     op_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             zero_q,   zero_d;
    logic             ovf_q,    ovf_d;

    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK-1:0] w_s;
    logic             w_cout;
    logic             w_ctop;

    assign w_a_slice = a_q[idx_q*CHUNK +: CHUNK];
    assign w_b_slice = b_q[idx_q*CHUNK +: CHUNK];

    alu_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .op_i   (op_q),
        .a_i    (w_a_slice),
        .b_i    (w_b_slice),
        .cin_i  (carry_q),
        .s_o    (w_s),
        .cout_o (w_cout),
        .ctop_o (w_ctop)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.op;
                    a_d     = bus.i0;
                    b_d     = bus.i1;
                    idx_d   = '0;
                    // SUB is a + ~b + 1: the +1 enters as the initial carry
                    carry_d = (bus.op == OP_SUB);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                result_d[idx_q*CHUNK +: CHUNK] = w_s;
                carry_d = w_cout;
                if (idx_q == LAST_IDX) begin
                    // Flags are frozen here so they stay stable throughout DONE
                    cout_d  = is_arith(op_q) & w_cout;
                    ovf_d   = is_arith(op_q) & (w_ctop ^ w_cout);
                    zero_d  = (result_d == '0);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_AND;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.o         = result_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;

endmodule : alu_seq
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits processed per cycle; WIDTH % CHUNK == 0, 1 <= CHUNK <= WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port op  input  2  operation: 00 AND, 01 OR, 10 ADD, 11 SUB (i0 - i1).
REQ-006 SHALL have ports i0, i1  input  WIDTH  operands.
REQ-007 SHALL have port in_valid  input  1  request present; in_ready  output  1  block can accept.
REQ-008 SHALL have port o  output  WIDTH  result.
REQ-009 SHALL have port cout  output  1  carry out of MSB (ADD/SUB), 0 for logic ops.
REQ-010 SHALL have ports zero, ovf  output  1 each  o == 0; signed overflow (ADD/SUB only, else 0).
REQ-011 SHALL have port out_valid  output  1  result valid; out_ready  input  1  consumer takes result.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE; in_valid ignored in RUN/DONE.
REQ-014 SHALL, on in_valid && in_ready, capture op, i0, i1, clear chunk index to 0, load carry = 0 (ADD) or 1 (SUB), go to RUN.
REQ-015 SHALL, each RUN cycle, process chunk k = index (bits k*CHUNK .. k*CHUNK+CHUNK-1): logic ops bitwise; ADD a+b+carry; SUB a+~b+carry; write chunk into result register, update carry register.
REQ-016 SHALL spend exactly N = WIDTH/CHUNK cycles in RUN; after chunk N-1 go to DONE.
REQ-017 SHALL assert out_valid in DONE only; accept at cycle T -> out_valid first high at cycle T+N+1.
REQ-018 SHALL hold o, cout, zero, ovf stable while out_valid is high.
REQ-019 SHALL leave DONE for IDLE on out_ready && out_valid; in_ready rises the following cycle (no same-cycle bypass).
REQ-020 SHALL compute cout = final carry (SUB: 1 = no borrow); ovf = carry into MSB XOR carry out of MSB.
REQ-021 SHALL compute zero from full WIDTH result in DONE.
REQ-022 SHALL handle CHUNK == WIDTH as N = 1 (one RUN cycle); arithmetic wraps modulo 2^WIDTH.
REQ-023 SHALL hold out_valid indefinitely under out_ready = 0 without corrupting result.

Reset
REQ-024 SHALL, when rst = 1 on a clock edge, enter IDLE regardless of state, abandoning any in-progress operation.
REQ-025 SHALL reset o = 0, cout = 0, zero = 0, ovf = 0, out_valid = 0, index = 0, carry = 0; in_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-026 SHALL place op encodings (OP_AND, OP_OR, OP_ADD, OP_SUB) and FSM state typedef in shared package alu_pkg.
REQ-027 SHALL use one combinational sub-module alu_chunk (CHUNK-bit slice: op, a, b, cin -> s, cout, carry into top bit) instantiated once and time-multiplexed.
REQ-028 SHALL reject illegal WIDTH/CHUNK at elaboration.

Verification (WIDTH=16, CHUNK=4)
REQ-029 SHALL test ADD 0xFFFF + 0x0001 -> o=0x0000, cout=1, zero=1, ovf=0, out_valid at T+5.
REQ-030 SHALL test SUB 0x8000 - 0x0001 -> o=0x7FFF, cout=1, ovf=1; SUB 0x0000 - 0x0001 -> o=0xFFFF, cout=0, ovf=0.
REQ-031 SHALL test AND 0xF0F0, 0x0FF0 -> 0x00F0; OR -> 0xFFF0; cout=0, ovf=0, zero=0.
REQ-032 SHALL test out_ready low 3 cycles in DONE -> outputs held, in_ready=0, toggled in_valid/i0 ignored; idle one cycle after handshake.
REQ-033 SHALL test rst asserted during RUN chunk 2 -> all outputs at reset values next cycle, in_ready=1, no out_valid for aborted op.
REQ-034 SHALL test WIDTH=16, CHUNK=16 ADD 0x7FFF + 0x0001 -> o=0x8000, ovf=1, out_valid at T+2.
